switch_debounce: RTL and testbench

SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

---
 rtl/board_pkg.sv | 15 +
 rtl/debounce_bit.sv | 54 +++++
 rtl/switch_debounce.sv | 62 ++++++
 tb/tb_switch_debounce.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// Board-level constants shared by the switch debouncer and any board wrapper.
// Default debounce timing is derived from the board clock so both stay in step.
package board_pkg;

    localparam int unsigned BOARD_CLK_HZ     = 100_000_000;
    localparam int unsigned DEB_TICK_HZ      = 1000;
    localparam int unsigned DEB_TICK_DIV     = BOARD_CLK_HZ / DEB_TICK_HZ;
    localparam int unsigned DEB_STABLE_TICKS = 10;

    // Counter width that stays at least 1 bit when the range collapses to a single value.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One debounced switch bit: stability counter, accepted level and edge pulses.
// o_accept is the combinational "load this tick" strobe, used by the parent for sw_changed.
module debounce_bit
    import board_pkg::*;
#(
    parameter int unsigned STABLE_TICKS = DEB_STABLE_TICKS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_tick,
    input  logic i_sync,
    output logic o_db,
    output logic o_rise,
    output logic o_fall,
    output logic o_accept
);

    localparam int unsigned CW = $clog2(STABLE_TICKS + 1);
    localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);

    logic [CW-1:0] r_cnt;
    logic          r_db;
    logic          r_rise;
    logic          r_fall;
    logic          w_mismatch;
    logic          w_accept;

    assign w_mismatch = i_sync ^ r_db;
    assign w_accept   = i_tick & w_mismatch & (r_cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_db   <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_accept & i_sync;
            r_fall <= w_accept & ~i_sync;
            if (i_tick) begin
                // Clearing on acceptance keeps cnt within 0..STABLE_TICKS-1.
                if (!w_mismatch || w_accept) r_cnt <= '0;
                else                         r_cnt <= r_cnt + 1'b1;
                if (w_accept) r_db <= i_sync;
            end
        end
    end

    assign o_db     = r_db;
    assign o_rise   = r_rise;
    assign o_fall   = r_fall;
    assign o_accept = w_accept;

endmodule

// File: rtl/switch_debounce.sv
// N-bit switch debouncer: two-flop synchronizer, shared sample-tick prescaler,
// and one debounce_bit per switch.
module switch_debounce
    import board_pkg::*;
#(
    parameter int unsigned N            = 16,
    parameter int unsigned TICK_DIV     = DEB_TICK_DIV,
    parameter int unsigned STABLE_TICKS = DEB_STABLE_TICKS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] sw_raw,
    output logic [N-1:0] sw_db,
    output logic [N-1:0] sw_rise,
    output logic [N-1:0] sw_fall,
    output logic         sw_changed
);

    localparam int unsigned PW = cnt_width(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [N-1:0]  r_sync1;
    logic [N-1:0]  r_sync2;
    logic [PW-1:0] r_pre;
    logic          r_changed;
    logic          w_tick;
    logic [N-1:0]  w_accept;

    assign w_tick = (r_pre == PRE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_pre     <= '0;
            r_changed <= 1'b0;
        end else begin
            r_sync1   <= sw_raw;
            r_sync2   <= r_sync1;
            r_pre     <= w_tick ? '0 : r_pre + 1'b1;
            r_changed <= |w_accept;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_bit
        debounce_bit #(
            .STABLE_TICKS (STABLE_TICKS)
        ) u_bit (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_tick   (w_tick),
            .i_sync   (r_sync2[g]),
            .o_db     (sw_db[g]),
            .o_rise   (sw_rise[g]),
            .o_fall   (sw_fall[g]),
            .o_accept (w_accept[g])
        );
    end

    assign sw_changed = r_changed;

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with N=16, TICK_DIV=4, STABLE_TICKS=3.
module tb_switch_debounce;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] sw_raw;
    logic [15:0] sw_db;
    logic [15:0] sw_rise;
    logic [15:0] sw_fall;
    logic        sw_changed;

    int n_assert = 0;
    int n_fail   = 0;
    int rise_n [16];
    int fall_n [16];
    int chg_n;

    switch_debounce #(.N(16), .TICK_DIV(4), .STABLE_TICKS(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw_raw     (sw_raw),
        .sw_db      (sw_db),
        .sw_rise    (sw_rise),
        .sw_fall    (sw_fall),
        .sw_changed (sw_changed)
    );

    always #5 clk = ~clk;

    // Pulse tallies: each posedge sees the value held during the previous cycle.
    always @(posedge clk) begin
        for (int i = 0; i < 16; i++) begin
            if (sw_rise[i] === 1'b1) rise_n[i] <= rise_n[i] + 1;
            if (sw_fall[i] === 1'b1) fall_n[i] <= fall_n[i] + 1;
        end
        if (sw_changed === 1'b1) chg_n <= chg_n + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns the number of negedges until (sw_db & mask) == val, or maxc+1 on timeout.
    task automatic wait_db(input logic [15:0] mask, input logic [15:0] val,
                           input int maxc, output int lat);
        lat = maxc + 1;
        for (int t = 1; t <= maxc; t++) begin
            @(negedge clk);
            if ((sw_db & mask) === val) begin
                lat = t;
                break;
            end
        end
    endtask

    function automatic int rise_sum();
        int s = 0;
        for (int i = 0; i < 16; i++) s += rise_n[i];
        return s;
    endfunction

    initial begin
        int lat;
        int snap_r, snap_f, snap_tot, snap_c;

        // Reset with all switches held high
        rst_n  = 1'b0;
        sw_raw = 16'hFFFF;
        step(3);
        chk("rst_db",   32'(sw_db),      32'h0);
        chk("rst_rise", 32'(sw_rise),    32'h0);
        chk("rst_fall", 32'(sw_fall),    32'h0);
        chk("rst_chg",  32'(sw_changed), 32'h0);
        rst_n = 1'b1;
        wait_db(16'hFFFF, 16'hFFFF, 15, lat);
        chk("rst_lat",      32'(lat),        32'd12);
        chk("rst_acc_db",   32'(sw_db),      32'hFFFF);
        chk("rst_acc_rise", 32'(sw_rise),    32'hFFFF);
        chk("rst_acc_chg",  32'(sw_changed), 32'h1);
        step(1);
        chk("rst_rise_off", 32'(sw_rise),    32'h0);
        chk("rst_chg_off",  32'(sw_changed), 32'h0);

        // Release everything
        sw_raw = 16'h0000;
        wait_db(16'hFFFF, 16'h0000, 20, lat);
        chk("rel_db",   32'(sw_db),   32'h0);
        chk("rel_fall", 32'(sw_fall), 32'hFFFF);
        step(2);

        // Clean press on bit 5
        snap_r   = rise_n[5];
        snap_tot = rise_sum();
        sw_raw   = 16'h0020;
        wait_db(16'h0020, 16'h0020, 20, lat);
        chk("press_lat_rng", 32'(lat >= 11 && lat <= 15), 32'h1);
        chk("press_db",      32'(sw_db),   32'h0020);
        chk("press_rise",    32'(sw_rise), 32'h0020);
        step(2);
        chk("press_rise_n",  32'(rise_n[5] - snap_r),   32'd1);
        chk("press_rise_tot",32'(rise_sum() - snap_tot), 32'd1);

        // Bounce on bit 2: 12 segments of 5 clocks, then held high
        snap_r = rise_n[2];
        for (int s = 0; s < 12; s++) begin
            sw_raw[2] = (s % 2 == 0);
            step(5);
            chk("bounce_hold", 32'(sw_db[2]), 32'h0);
        end
        sw_raw[2] = 1'b1;
        wait_db(16'h0004, 16'h0004, 20, lat);
        chk("bounce_lat_rng", 32'(lat >= 11 && lat <= 15), 32'h1);
        step(2);
        chk("bounce_rise_n", 32'(rise_n[2] - snap_r), 32'd1);
        chk("bounce_db",     32'(sw_db), 32'h0024);

        // Glitch on bit 0
        snap_r = rise_n[0];
        snap_f = fall_n[0];
        sw_raw[0] = 1'b1;
        step(6);
        sw_raw[0] = 1'b0;
        step(20);
        chk("glitch_db",     32'(sw_db), 32'h0024);
        chk("glitch_rise_n", 32'(rise_n[0] - snap_r), 32'd0);
        chk("glitch_fall_n", 32'(fall_n[0] - snap_f), 32'd0);

        // Simultaneous rise on bits 15 and 0, then fall of bit 15 alone
        sw_raw = 16'h0000;
        wait_db(16'hFFFF, 16'h0000, 20, lat);
        chk("sim_clear", 32'(sw_db), 32'h0);
        step(2);
        sw_raw = 16'h8001;
        wait_db(16'h8001, 16'h8001, 20, lat);
        chk("sim_db",   32'(sw_db),      32'h8001);
        chk("sim_rise", 32'(sw_rise),    32'h8001);
        chk("sim_chg",  32'(sw_changed), 32'h1);
        step(2);
        sw_raw = 16'h0001;
        wait_db(16'h8000, 16'h0000, 20, lat);
        chk("sim_fall",    32'(sw_fall), 32'h8000);
        chk("sim_fall_rs", 32'(sw_rise), 32'h0);
        chk("sim_fall_db", 32'(sw_db),   32'h0001);
        step(1);
        chk("sim_fall_off", 32'(sw_fall), 32'h0);

        // Reset after two ticks of mismatch on bit 7
        sw_raw = 16'h0000;
        wait_db(16'hFFFF, 16'h0000, 20, lat);
        step(2);
        sw_raw = 16'h0080;
        step(10);
        chk("mid_pre_db", 32'(sw_db), 32'h0);
        snap_c = chg_n;
        snap_r = rise_n[7];
        rst_n = 1'b0;
        #1;
        chk("mid_rst_db",   32'(sw_db),   32'h0);
        chk("mid_rst_rise", 32'(sw_rise), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(11);
        chk("mid_wait_db",  32'(sw_db), 32'h0);
        chk("mid_no_pulse", 32'(chg_n - snap_c), 32'd0);
        chk("mid_no_rise",  32'(rise_n[7] - snap_r), 32'd0);
        step(1);
        chk("mid_acc_db",   32'(sw_db),   32'h0080);
        chk("mid_acc_rise", 32'(sw_rise), 32'h0080);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
